// File: rtl/alu_secuencial_if.sv
// Request/result bus of the sequential ALU; one start handshake, one result pulse.
// Handshake: a request is taken on the rising edge where inicio=1 and listo=1; valido pulses once when results change.
interface alu_secuencial_if #(
   parameter int N = 4
);
   logic         inicio;
   logic [N-1:0] entrada1;
   logic [N-1:0] entrada2;
   logic [3:0]   selector;
   logic         listo;
   logic         valido;
   logic [N-1:0] resultado;
   logic         carry;
   logic         cero;
   logic         negativo;
   logic         desbordamiento;
   logic         error;
   logic [1:0]   estado;

   modport master (
      output inicio, entrada1, entrada2, selector,
      input  listo, valido, resultado, carry, cero, negativo, desbordamiento, error, estado
   );

   modport slave (
      input  inicio, entrada1, entrada2, selector,
      output listo, valido, resultado, carry, cero, negativo, desbordamiento, error, estado
   );
endinterface

// File: rtl/alu_secuencial.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative multiply, divide, modulo and exponent.
// Results and flags are registered on the edge entering FIN and held until the next operation.
module alu_secuencial #(
   parameter int N = 4
) (
   input logic             clk,
   input logic             rst,
   alu_secuencial_if.slave bus
);
   localparam logic [3:0] OP_SUMA  = 4'b0001;
   localparam logic [3:0] OP_RESTA = 4'b0010;
   localparam logic [3:0] OP_MULT  = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_MOD   = 4'b0101;
   localparam logic [3:0] OP_AND   = 4'b0110;
   localparam logic [3:0] OP_OR    = 4'b0111;
   localparam logic [3:0] OP_XOR   = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b1001;
   localparam logic [3:0] OP_SRL   = 4'b1010;
   localparam logic [3:0] OP_EXP   = 4'b1011;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CALCULO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   estado_t        estado, estado_sig;
   logic [N-1:0]   a_q, b_q, cnt;
   logic [3:0]     op_q;
   logic [2*N-1:0] prod_q, prod_d;
   logic           sticky_q, sticky_d;

   logic [N-1:0]   res_q;
   logic           valido_q, carry_q, cero_q, neg_q, ovf_q, err_q;

   logic [3:0]     op_m;
   logic [N-1:0]   a_m, b_m;
   logic           iterativa, cargar, terminar;
   logic [N:0]     mul_sum, div_trial, suma_ext;
   logic [2*N-1:0] exp_full;
   logic [N-1:0]   resta;
   logic [N-1:0]   res_d;
   logic           carry_d, neg_d, ovf_d, err_d;

   assign iterativa = (bus.selector == OP_MULT) || (bus.selector == OP_DIV) ||
                      (bus.selector == OP_MOD)  ||
                      ((bus.selector == OP_EXP) && (bus.entrada2 != '0));

   always_comb begin
      estado_sig = estado;
      cargar     = 1'b0;
      terminar   = 1'b0;
      case (estado)
         REPOSO: begin
            if (bus.inicio) begin
               cargar = 1'b1;
               if (iterativa) begin
                  estado_sig = CALCULO;
               end else begin
                  estado_sig = FIN;
                  terminar   = 1'b1;
               end
            end
         end
         CALCULO: begin
            if (cnt == '0) begin
               estado_sig = FIN;
               terminar   = 1'b1;
            end
         end
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   // Single-cycle ops finish on the accepting edge, so they read the live inputs.
   assign op_m = (estado == REPOSO) ? bus.selector : op_q;
   assign a_m  = (estado == REPOSO) ? bus.entrada1 : a_q;
   assign b_m  = (estado == REPOSO) ? bus.entrada2 : b_q;

   // prod_q holds {high, low} for mult, {remainder, quotient} for div/mod, {-, acc} for exp.
   always_comb begin
      prod_d    = prod_q;
      sticky_d  = sticky_q;
      mul_sum   = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, a_q} : '0);
      div_trial = {prod_q[2*N-1:N], prod_q[N-1]} - {1'b0, b_q};
      exp_full  = {{N{1'b0}}, prod_q[N-1:0]} * {{N{1'b0}}, a_q};
      case (op_q)
         OP_MULT: prod_d = {mul_sum, prod_q[N-1:1]};
         OP_DIV, OP_MOD: begin
            if (b_q != '0) begin
               if (div_trial[N]) prod_d = {prod_q[2*N-2:0], 1'b0};
               else              prod_d = {div_trial[N-1:0], prod_q[N-2:0], 1'b1};
            end
         end
         OP_EXP: begin
            prod_d   = {{N{1'b0}}, exp_full[N-1:0]};
            sticky_d = sticky_q | (|exp_full[2*N-1:N]);
         end
         default: ;
      endcase
   end

   always_comb begin
      res_d    = '0;
      carry_d  = 1'b0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      suma_ext = {1'b0, a_m} + {1'b0, b_m};
      resta    = a_m - b_m;
      case (op_m)
         OP_SUMA: begin
            res_d   = suma_ext[N-1:0];
            carry_d = suma_ext[N];
            neg_d   = suma_ext[N-1];
            ovf_d   = (a_m[N-1] == b_m[N-1]) && (suma_ext[N-1] != a_m[N-1]);
         end
         OP_RESTA: begin
            res_d   = resta;
            carry_d = (a_m < b_m);
            neg_d   = resta[N-1];
            ovf_d   = (a_m[N-1] != b_m[N-1]) && (resta[N-1] != a_m[N-1]);
         end
         OP_MULT: begin
            res_d   = prod_d[N-1:0];
            carry_d = |prod_d[2*N-1:N];
            ovf_d   = |prod_d[2*N-1:N];
         end
         OP_DIV: begin
            if (b_m == '0) begin
               res_d = '1;
               ovf_d = 1'b1;
            end else begin
               res_d = prod_d[N-1:0];
            end
         end
         OP_MOD: begin
            if (b_m == '0) begin
               res_d = a_m;
               ovf_d = 1'b1;
            end else begin
               res_d = prod_d[2*N-1:N];
            end
         end
         OP_AND: res_d = a_m & b_m;
         OP_OR:  res_d = a_m | b_m;
         OP_XOR: res_d = a_m ^ b_m;
         OP_SLL: res_d = (b_m >= N'(N)) ? '0 : (a_m << b_m);
         OP_SRL: res_d = (b_m >= N'(N)) ? '0 : (a_m >> b_m);
         OP_EXP: begin
            if (b_m == '0) begin
               res_d = N'(1);
            end else begin
               res_d   = prod_d[N-1:0];
               carry_d = sticky_d;
               ovf_d   = sticky_d;
            end
         end
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado   <= REPOSO;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt      <= '0;
         prod_q   <= '0;
         sticky_q <= 1'b0;
         res_q    <= '0;
         valido_q <= 1'b0;
         carry_q  <= 1'b0;
         cero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         estado   <= estado_sig;
         valido_q <= terminar;
         if (cargar) begin
            a_q      <= bus.entrada1;
            b_q      <= bus.entrada2;
            op_q     <= bus.selector;
            sticky_q <= 1'b0;
            cnt      <= (bus.selector == OP_EXP) ? (bus.entrada2 - N'(1)) : N'(N - 1);
            case (bus.selector)
               OP_MULT:        prod_q <= {{N{1'b0}}, bus.entrada2};
               OP_DIV, OP_MOD: prod_q <= {{N{1'b0}}, bus.entrada1};
               OP_EXP:         prod_q <= {{N{1'b0}}, N'(1)};
               default:        prod_q <= '0;
            endcase
         end else if (estado == CALCULO) begin
            prod_q   <= prod_d;
            sticky_q <= sticky_d;
            cnt      <= cnt - N'(1);
         end
         if (terminar) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            cero_q  <= (res_d == '0);
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
         end
      end
   end

   assign bus.listo          = (estado == REPOSO);
   assign bus.valido         = valido_q;
   assign bus.resultado      = res_q;
   assign bus.carry          = carry_q;
   assign bus.cero           = cero_q;
   assign bus.negativo       = neg_q;
   assign bus.desbordamiento = ovf_q;
   assign bus.error          = err_q;
   assign bus.estado         = estado;
endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial: directed cases, handshake and reset scenarios, then random operations
// checked against an arithmetic reference model.
module tb_alu_secuencial;
   localparam int N = 4;
   localparam int W = N + 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_secuencial_if #(.N(N)) bus ();
   alu_secuencial #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   // Expected {error, desbordamiento, negativo, cero, carry, resultado} and valido latency.
   function automatic logic [W-1:0] modelo(input int op, input int a, input int b, output int lat);
      int m, res, c, ng, ov, er, s, sa, sb, acc, p;
      m = 1 << N; res = 0; c = 0; ov = 0; er = 0; lat = 1;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      case (op)
         1: begin
            s = a + b; res = s % m; c = (s >= m);
            s = sa + sb; ov = (s < -m / 2) || (s >= m / 2);
         end
         2: begin
            res = (a - b + m) % m; c = (a < b);
            s = sa - sb; ov = (s < -m / 2) || (s >= m / 2);
         end
         3: begin p = a * b; res = p % m; c = (p >= m); ov = c; lat = N + 1; end
         4: begin lat = N + 1; if (b == 0) begin res = m - 1; ov = 1; end else res = a / b; end
         5: begin lat = N + 1; if (b == 0) begin res = a; ov = 1; end else res = a % b; end
         6: res = a & b;
         7: res = a | b;
         8: res = a ^ b;
         9: res = (b >= N) ? 0 : (a << b) % m;
         10: res = (b >= N) ? 0 : a >> b;
         11: begin
            acc = 1;
            for (int i = 0; i < b; i++) begin
               p = acc * a;
               if (p >= m) c = 1;
               acc = p % m;
            end
            res = acc; ov = c; lat = b + 1;
         end
         default: er = 1;
      endcase
      ng = ((op == 1) || (op == 2)) && (res >= m / 2);
      return {er[0], ov[0], ng[0], (res == 0), c[0], res[N-1:0]};
   endfunction

   // Called at a negedge; returns at the negedge following the valido cycle.
   task automatic ejecutar(input int op, input int a, input int b, input string tag, input bit mantener);
      int lat_esp, lat, espera;
      logic [W-1:0] esp;
      esp = modelo(op, a, b, lat_esp);
      exp_q.push_back(esp);
      espera = 0;
      while (bus.listo !== 1'b1 && espera < 50) begin
         @(negedge clk);
         espera++;
      end
      comprobar({tag, " listo_antes"}, bus.listo, 1);
      bus.inicio   = 1'b1;
      bus.entrada1 = N'(a);
      bus.entrada2 = N'(b);
      bus.selector = 4'(op);
      @(posedge clk);
      @(negedge clk);
      if (!mantener) bus.inicio = 1'b0;
      lat = 1;
      while (bus.valido !== 1'b1 && lat < 100) begin
         if (mantener) begin
            comprobar({tag, " listo_ocupado"}, bus.listo, 0);
            bus.entrada1 = N'($urandom_range(0, (1 << N) - 1));
            bus.entrada2 = N'($urandom_range(0, (1 << N) - 1));
         end
         @(negedge clk);
         lat++;
      end
      bus.inicio = 1'b0;
      comprobar({tag, " latencia"}, lat, lat_esp);
      esp = exp_q.pop_front();
      comprobar({tag, " resultado"}, bus.resultado, esp[N-1:0]);
      comprobar({tag, " carry"}, bus.carry, esp[N]);
      comprobar({tag, " cero"}, bus.cero, esp[N+1]);
      comprobar({tag, " negativo"}, bus.negativo, esp[N+2]);
      comprobar({tag, " desbordamiento"}, bus.desbordamiento, esp[N+3]);
      comprobar({tag, " error"}, bus.error, esp[N+4]);
      comprobar({tag, " listo_en_fin"}, bus.listo, 0);
      @(negedge clk);
      comprobar({tag, " valido_pulso"}, bus.valido, 0);
      comprobar({tag, " listo_despues"}, bus.listo, 1);
      comprobar({tag, " resultado_retenido"}, bus.resultado, esp[N-1:0]);
   endtask

   int dir_op[] = '{1, 2, 1, 3, 3, 4, 5, 4, 5, 11, 11, 11, 14, 0, 9, 9, 10, 10, 6, 7, 8};
   int dir_a[]  = '{7, 3, 7, 6, 3, 13, 13, 9, 9, 3, 2, 7, 5, 3, 3, 3, 12, 12, 12, 10, 15};
   int dir_b[]  = '{9, 5, 1, 5, 5, 4, 4, 0, 0, 2, 4, 0, 6, 3, 3, 4, 2, 15, 10, 5, 9};

   initial begin
      int op, a, b, pulsos;
      rst          = 1'b1;
      bus.inicio   = 1'b0;
      bus.entrada1 = '0;
      bus.entrada2 = '0;
      bus.selector = '0;
      repeat (2) @(negedge clk);
      comprobar("reset listo", bus.listo, 1);
      comprobar("reset valido", bus.valido, 0);
      comprobar("reset resultado", bus.resultado, 0);
      comprobar("reset flags", {bus.carry, bus.cero, bus.negativo, bus.desbordamiento, bus.error}, 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (dir_op[i]) ejecutar(dir_op[i], dir_a[i], dir_b[i], $sformatf("dir%0d", i), 1'b0);

      ejecutar(3, 6, 5, "mantener", 1'b1);
      pulsos = 0;
      repeat (N + 3) begin
         @(negedge clk);
         if (bus.valido === 1'b1) pulsos++;
      end
      comprobar("mantener pulsos_extra", pulsos, 0);
      comprobar("mantener listo_final", bus.listo, 1);

      ejecutar(2, 3, 5, "pre_reset", 1'b0);
      bus.inicio   = 1'b1;
      bus.entrada1 = N'(6);
      bus.entrada2 = N'(5);
      bus.selector = 4'd3;
      @(posedge clk);
      @(negedge clk);
      bus.inicio = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      comprobar("abortar resultado", bus.resultado, 0);
      comprobar("abortar flags", {bus.carry, bus.cero, bus.negativo, bus.desbordamiento, bus.error}, 0);
      comprobar("abortar listo", bus.listo, 1);
      comprobar("abortar valido", bus.valido, 0);
      @(negedge clk);
      rst = 1'b0;
      pulsos = 0;
      repeat (N + 3) begin
         @(negedge clk);
         if (bus.valido === 1'b1) pulsos++;
      end
      comprobar("abortar sin_valido", pulsos, 0);
      ejecutar(1, 2, 3, "post_reset", 1'b0);

      for (int k = 0; k < 200; k++) begin
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, (1 << N) - 1);
         b  = (op == 11) ? $urandom_range(0, 6) : $urandom_range(0, (1 << N) - 1);
         ejecutar(op, a, b, $sformatf("rnd%0d op%0d", k, op), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Parametrised, multi-cycle successor to the combinational 4-bit ALU, keeping the same opcode encoding.
- Operands and opcode are captured on a start handshake.
- Single-cycle operations finish in one cycle.
- Multiply, divide, modulo and exponent are computed iteratively.
- Result and flags are registered and held until the next operation, so the block can sit directly behind a register file or a 7-segment display driver.

Parameters:
N, 4, operand and result width in bits (N >= 2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
inicio  input  1  start request; accepted only when listo=1.
entrada1  input  N  operand A, unsigned (two's complement for the negativo/desbordamiento flags of add and subtract).
entrada2  input  N  operand B, or the shift amount, or the exponent.
selector  input  4  opcode.
listo  output  1  block idle, ready to accept inicio.
valido  output  1  one-cycle pulse: result and flags are updated.
resultado  output  N  registered result.
carry  output  1  registered carry/borrow flag.
cero  output  1  registered zero flag (resultado == 0).
negativo  output  1  registered sign flag.
desbordamiento  output  1  registered overflow flag.
error  output  1  registered illegal-opcode flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to REPOSO; listo=1.
  - valido, resultado, carry, cero, negativo, desbordamiento and error all go to 0.
  - Reset asserted mid-operation aborts the operation; no valido is produced.
- State machine: REPOSO -> CALCULO -> FIN -> REPOSO.
  - REPOSO: listo=1. When inicio=1, capture entrada1, entrada2 and selector, then go to CALCULO for iterative ops or to FIN for single-cycle ops.
  - CALCULO: listo=0. Iteration counter runs; inicio is ignored.
  - FIN: write resultado and all flags, pulse valido for exactly one cycle, return to REPOSO. listo=0 in FIN, listo=1 again the following cycle.
- Latency (start accepted at edge t):
  - Single-cycle ops and illegal opcodes: valido high in cycle t+1.
  - mult, div, mod: valido in cycle t+N+1.
  - exp: valido in cycle t+B+1, where B = captured entrada2; B=0 gives t+1.
- Operations (A, B are the captured operands). Unless stated, negativo, carry and desbordamiento are 0; error=0 for every legal opcode.
  - 0001 suma: {carry,resultado}=A+B. negativo=resultado[N-1]. desbordamiento = signed overflow (A, B same sign, result sign differs).
  - 0010 resta: resultado=A-B mod 2^N. carry=borrow (A<B unsigned). negativo=resultado[N-1]. desbordamiento = signed overflow.
  - 0011 mult: unsigned shift-add over N iterations into a 2N-bit product. resultado = low N bits. carry = desbordamiento = OR of the high N bits.
  - 0100 div: unsigned restoring division over N iterations; resultado = quotient.
  - 0101 mod: same datapath as div; resultado = remainder.
  - Divide by zero (div or mod): desbordamiento=1, no iteration; valido still at t+N+1. Result is all ones for div and A for mod.
  - 0110 and, 0111 or, 1000 xor: bitwise operation.
  - 1001 sll, 1010 srl: logical shift of A by B. B >= N gives 0.
  - 1011 exp: acc starts at 1, acc = acc*A truncated to N bits, once per cycle for B cycles. carry = desbordamiento = 1 if any iteration's full product is >= 2^N (sticky).
  - 0000, 1100-1111: resultado=0, error=1, all other flags 0.
- cero is computed from the final N-bit resultado for every opcode, including divide by zero and illegal opcodes.
- Outputs change only in FIN and hold their values between operations.
- inicio asserted in the same cycle as valido is ignored, because listo=0 in FIN.

Test Plan:
- Add: N=4, suma 0111+1001 -> valido at t+1; resultado=0000, carry=1, cero=1, desbordamiento=0. Subtract: resta 0011-0101 -> resultado=1110, carry=1, negativo=1, desbordamiento=0. Signed overflow: suma 0111+0001 -> resultado=1000, desbordamiento=1, negativo=1.
- Multiply: mult 6*5 -> valido exactly at t+5, resultado=1110, carry=1, desbordamiento=1. mult 3*5 -> resultado=1111, carry=0.
- Divide and modulo: div 13/4 -> resultado=0011. mod 13%4 -> resultado=0001. div 9/0 -> resultado=1111, desbordamiento=1, valido at t+5.
- Exponent: exp 3^2 -> resultado=1001, valido at t+3. exp 2^4 -> resultado=0000, cero=1, carry=1, desbordamiento=1. exp 7^0 -> resultado=0001, valido at t+1.
- Handshake: inicio held high throughout a mult with changing operands -> only the first request is executed, listo=0 until the cycle after valido, and exactly one valido pulse per accepted start. Illegal opcode 1110 -> error=1, resultado=0, cero=1.
- Reset: assert rst during cycle t+2 of a mult -> all outputs go to 0 immediately, listo=1, no valido. A subsequent suma 0010+0011 gives resultado=0101.
